message_sequencer: RTL

- Streams a fixed 4-bit-coded text message, one character per handshake, to the display driver.
- Generalises the single hardwired message block: selectable message, internal character counter, valid/ready output handshake, optional repeat and space padding.
- Sits between the control FSM, which issues start, message select and stop, and the display writer, which consumes characters.

---
 rtl/message_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/message_sequencer.sv
// message_sequencer: streams one of a small set of fixed 4-bit-coded text
// messages, one character per valid/ready handshake, with optional frame
// repeat and optional SPACE padding up to MAX_LEN characters.
module message_sequencer #(
  parameter int CHAR_W  = 4,
  parameter int NUM_MSG = 4,
  parameter int SEL_W   = 2,
  parameter int MAX_LEN = 16,
  parameter int IDX_W   = 4,
  parameter int PAD_EN  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SEL_W-1:0]  msg_sel,
  input  logic              repeat_en,
  input  logic              stop,
  input  logic              char_ready,
  output logic [CHAR_W-1:0] char,
  output logic              char_valid,
  output logic [IDX_W-1:0]  char_index,
  output logic              last_char,
  output logic [IDX_W:0]    len_string,
  output logic              busy,
  output logic              done,
  output logic              sel_error
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  localparam logic [CHAR_W-1:0] C_A  = CHAR_W'(0);
  localparam logic [CHAR_W-1:0] C_C  = CHAR_W'(1);
  localparam logic [CHAR_W-1:0] C_D  = CHAR_W'(2);
  localparam logic [CHAR_W-1:0] C_E  = CHAR_W'(3);
  localparam logic [CHAR_W-1:0] C_I  = CHAR_W'(4);
  localparam logic [CHAR_W-1:0] C_J  = CHAR_W'(5);
  localparam logic [CHAR_W-1:0] C_N  = CHAR_W'(6);
  localparam logic [CHAR_W-1:0] C_O  = CHAR_W'(7);
  localparam logic [CHAR_W-1:0] C_P  = CHAR_W'(8);
  localparam logic [CHAR_W-1:0] C_R  = CHAR_W'(9);
  localparam logic [CHAR_W-1:0] C_T  = CHAR_W'(10);
  localparam logic [CHAR_W-1:0] C_S  = CHAR_W'(11);
  localparam logic [CHAR_W-1:0] C_SP = CHAR_W'(15);

  logic [0:0]       state;
  logic [IDX_W-1:0] idx;
  logic [SEL_W-1:0] sel_lat;
  logic             rep_lat;
  logic [IDX_W:0]   len_lat;
  logic             done_r;
  logic             sel_err_r;
  logic [IDX_W:0]   frame_len;
  logic             sel_ok;
  logic             handshake;
  logic             is_last;

  // Unpadded length of each message in the ROM
  function automatic logic [IDX_W:0] msg_len(input logic [SEL_W-1:0] s);
    msg_len = '0;
    case (int'(s))
      0:       msg_len = (IDX_W+1)'(9);
      1:       msg_len = (IDX_W+1)'(6);
      2:       msg_len = (IDX_W+1)'(7);
      3:       msg_len = (IDX_W+1)'(6);
      default: msg_len = '0;
    endcase
  endfunction

  // Character ROM; any position past the end of the text reads as SPACE
  function automatic logic [CHAR_W-1:0] msg_char(input logic [SEL_W-1:0] s,
                                                 input logic [IDX_W-1:0] p);
    msg_char = C_SP;
    case (int'(s))
      0: case (int'(p))   // REJEITADO
           0: msg_char = C_R;
           1: msg_char = C_E;
           2: msg_char = C_J;
           3: msg_char = C_E;
           4: msg_char = C_I;
           5: msg_char = C_T;
           6: msg_char = C_A;
           7: msg_char = C_D;
           8: msg_char = C_O;
           default: ;
         endcase
      1: case (int'(p))   // ACEITO
           0: msg_char = C_A;
           1: msg_char = C_C;
           2: msg_char = C_E;
           3: msg_char = C_I;
           4: msg_char = C_T;
           5: msg_char = C_O;
           default: ;
         endcase
      2: case (int'(p))   // INSERIR
           0: msg_char = C_I;
           1: msg_char = C_N;
           2: msg_char = C_S;
           3: msg_char = C_E;
           4: msg_char = C_R;
           5: msg_char = C_I;
           6: msg_char = C_R;
           default: ;
         endcase
      3: case (int'(p))   // PRONTO
           0: msg_char = C_P;
           1: msg_char = C_R;
           2: msg_char = C_O;
           3: msg_char = C_N;
           4: msg_char = C_T;
           5: msg_char = C_O;
           default: ;
         endcase
      default: ;
    endcase
  endfunction

  // Request decode and output view of the registered state
  always_comb begin
    frame_len  = (PAD_EN != 0) ? (IDX_W+1)'(MAX_LEN) : msg_len(msg_sel);
    sel_ok     = ({1'b0, msg_sel} < (SEL_W+1)'(NUM_MSG));
    char_valid = (state == S_SEND);
    busy       = (state == S_SEND);
    is_last    = ({1'b0, idx} == (len_lat - (IDX_W+1)'(1)));
    handshake  = char_valid & char_ready;
    last_char  = char_valid & is_last;
    char       = char_valid ? msg_char(sel_lat, idx) : '0;
    char_index = idx;
    len_string = len_lat;
    done       = done_r;
    sel_error  = sel_err_r;
  end

  // Control FSM: frame start, index advance, wrap/repeat, stop and pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      rep_lat   <= 1'b0;
      len_lat   <= '0;
      done_r    <= 1'b0;
      sel_err_r <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      sel_err_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (sel_ok) begin
              rep_lat <= repeat_en;
              len_lat <= frame_len;
              idx     <= '0;
              state   <= S_SEND;
            end else begin
              sel_err_r <= 1'b1;
            end
          end
        end
        default: begin
          // start is ignored here; stop wins over repeat on the last char
          if (handshake && is_last) begin
            done_r <= 1'b1;
            idx    <= '0;
            if (stop || !rep_lat) state <= S_IDLE;
          end else if (stop) begin
            idx   <= '0;
            state <= S_IDLE;
          end else if (handshake) begin
            idx <= idx + IDX_W'(1);
          end
        end
      endcase
    end
  end

  // Message select is datapath only; it is read solely while char_valid=1
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start && sel_ok) sel_lat <= msg_sel;
  end

endmodule
